// File: rtl/wave_voice_sched.sv
`default_nettype none
// ============================================================================
//  Module   : wave_voice_sched
//  Purpose  : Time-multiplexes one wave LUT across NUM_VOICES phase
//             accumulators and sums their samples into one mix per tick.
//             Define WAVE_VOICE_SCHED_MUTE_EN to add a per-voice mute input.
//  Revision : 1.0  initial release
// ============================================================================
module wave_voice_sched #(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 16,
    // Derived width; leave at its default.
    parameter int MIX_W      = 16 + $clog2(NUM_VOICES)
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          tick_in,
    input  logic [NUM_VOICES*PHASE_W-1:0] freq_in,
    input  logic [NUM_VOICES*3-1:0]       type_in,
`ifdef WAVE_VOICE_SCHED_MUTE_EN
    input  logic [NUM_VOICES-1:0]         mute_in,
`endif
    output logic [3:0]                    lut_addr_out,
    output logic [2:0]                    lut_type_out,
    input  logic [15:0]                   lut_data_in,
    input  logic                          wr_req_in,
    input  logic [3:0]                    wr_addr_in,
    input  logic [3:0]                    wr_data_in,
    output logic                          wr_ack_out,
    output logic [3:0]                    mem_write_addr_out,
    output logic [3:0]                    mem_write_data_out,
    output logic                          mem_write_en_out,
    output logic [MIX_W-1:0]              mix_out,
    output logic                          mix_valid_out,
    output logic                          busy_out,
    output logic                          overrun_out
);

    localparam int                c_SLOT_W    = $clog2(NUM_VOICES);
    localparam logic [c_SLOT_W-1:0] c_LAST_SLOT = c_SLOT_W'(NUM_VOICES - 1);
    localparam logic [c_SLOT_W-1:0] c_SLOT_ONE  = c_SLOT_W'(1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_SLOT = 1'b1;

    logic [0:0]                        r_state;
    logic [0:0]                        w_state_nxt;
    logic [c_SLOT_W-1:0]               r_slot;
    logic [c_SLOT_W-1:0]               w_slot_nxt;
    logic                              w_frame_start;
    logic                              w_frame_last;
    logic                              w_in_slot;

    logic [NUM_VOICES-1:0][PHASE_W-1:0] r_phase;
    logic [MIX_W-1:0]                  r_acc;
    logic [MIX_W-1:0]                  r_mix;
    logic                              r_mix_valid;
    logic                              r_overrun;

    logic [PHASE_W-1:0]                w_freq [NUM_VOICES];
    logic [2:0]                        w_type [NUM_VOICES];
    logic [NUM_VOICES-1:0]             w_mute;
    logic [15:0]                       w_sample;
    logic [MIX_W-1:0]                  w_acc_sum;

    logic                              w_wr_accept;
    logic                              r_wr_ack;
    logic [3:0]                        r_wr_addr;
    logic [3:0]                        r_wr_data;

    generate
        for (genvar v = 0; v < NUM_VOICES; v++) begin : g_unpack
            assign w_freq[v] = freq_in[v*PHASE_W +: PHASE_W];
            assign w_type[v] = type_in[v*3 +: 3];
`ifdef WAVE_VOICE_SCHED_MUTE_EN
            assign w_mute[v] = mute_in[v];
`else
            assign w_mute[v] = 1'b0;
`endif
        end
    endgenerate

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= c_ST_IDLE;
            r_slot  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_slot  <= w_slot_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_slot_nxt    = r_slot;
        w_frame_start = 1'b0;
        w_frame_last  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (tick_in) begin
                    w_state_nxt   = c_ST_SLOT;
                    w_slot_nxt    = '0;
                    w_frame_start = 1'b1;
                end
            end
            c_ST_SLOT: begin
                if (r_slot == c_LAST_SLOT) begin
                    w_state_nxt  = c_ST_IDLE;
                    w_slot_nxt   = '0;
                    w_frame_last = 1'b1;
                end else begin
                    w_slot_nxt = r_slot + c_SLOT_ONE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_slot_nxt  = '0;
            end
        endcase
    end

    assign w_in_slot    = (r_state == c_ST_SLOT);
    assign busy_out     = w_in_slot;
    assign lut_addr_out = w_in_slot ? r_phase[r_slot][PHASE_W-1 -: 4] : 4'd0;
    assign lut_type_out = w_in_slot ? w_type[r_slot] : 3'd0;

    // A muted voice still walks its phase; only its contribution is dropped.
    assign w_sample  = w_mute[r_slot] ? 16'd0 : lut_data_in;
    assign w_acc_sum = r_acc + {{(MIX_W-16){1'b0}}, w_sample};

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_phase     <= '0;
            r_acc       <= '0;
            r_mix       <= '0;
            r_mix_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_mix_valid <= 1'b0;
            r_overrun   <= w_in_slot && tick_in;
            if (w_frame_start) begin
                r_acc <= '0;
            end else if (w_in_slot) begin
                r_acc           <= w_acc_sum;
                r_phase[r_slot] <= r_phase[r_slot] + w_freq[r_slot];
                if (w_frame_last) begin
                    r_mix       <= w_acc_sum;
                    r_mix_valid <= 1'b1;
                end
            end
        end
    end

    assign mix_out       = r_mix;
    assign mix_valid_out = r_mix_valid;
    assign overrun_out   = r_overrun;

    // Writes only land in IDLE with no tick pending, so a frame never sees
    // the table change underneath it; the ack term blocks a double accept.
    assign w_wr_accept = wr_req_in && !w_in_slot && !tick_in && !r_wr_ack;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_wr_ack  <= 1'b0;
            r_wr_addr <= 4'd0;
            r_wr_data <= 4'd0;
        end else begin
            r_wr_ack <= w_wr_accept;
            if (w_wr_accept) begin
                r_wr_addr <= wr_addr_in;
                r_wr_data <= wr_data_in;
            end
        end
    end

    assign wr_ack_out         = r_wr_ack;
    assign mem_write_en_out   = r_wr_ack;
    assign mem_write_addr_out = r_wr_addr;
    assign mem_write_data_out = r_wr_data;

endmodule
`default_nettype wire
